branch_unit: RTL and testbench
==============================

# branch_unit

Sequential next-PC and status-flag unit for the non-pipelined LEGv8 core. It consumes the branch and flag-update controls that the decode control block produces. It owns the program counter register and the NZCV status register. Each retiring instruction, it resolves unconditional, conditional, CBZ and CBNZ branches into the next PC. It also keeps a taken-branch counter and a sticky illegal-op flag for debug.

## Interface
- ADDR_WIDTH, 64, width of PC and offset
- RESET_PC, 0, PC value loaded at reset
- CNT_WIDTH, 32, width of taken-branch counter
- clk  in  1  core clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- advance  in  1  instruction retires this cycle; PC, flags and counter update only when high
- branch_op  in  3  000 none, 001 B, 010 B.cond, 011 CBZ, 100 CBNZ, 101–111 illegal
- update_sreg  in  1  load NZCV from ALU flags on retire
- alu_n, alu_z, alu_c, alu_v  in  1 each  current-cycle ALU flags
- cond  in  4  B.cond condition field (instr[3:0])
- offset  in  ADDR_WIDTH  sign-extended word offset from decode
- pc  out  ADDR_WIDTH  current PC, registered
- flags  out  4  NZCV, registered, bit3=N … bit0=V
- taken  out  1  registered; high for the cycle after a retired taken branch
- branch_count  out  CNT_WIDTH  retired taken branches, saturating
- bad_op  out  1  sticky; set on a retired illegal branch_op

## Operation
- Target = pc + (offset << 2), modulo 2^ADDR_WIDTH. Wrap-around is silent and required.
- Fall-through = pc + 4, modulo 2^ADDR_WIDTH.
- Taken decision:
  - B: always taken.
  - CBZ: taken when alu_z = 1.
  - CBNZ: taken when alu_z = 0.
  - B.cond: taken when cond_eval(flags, cond) is true.
  - none or illegal: not taken.
- B.cond evaluates the registered flags, i.e. the value before this cycle's update. With update_sreg and B.cond in the same cycle, the old flags decide the branch and the new flags load at the edge.
- Condition codes, ARM encoding:
  - EQ Z; NE !Z; HS C; LO !C; MI N; PL !N; VS V; VC !V
  - HI C&!Z; LS !(C&!Z); GE N==V; LT N!=V
  - GT !Z&(N==V); LE !(GT)
  - AL and NV (1110, 1111) both always true.
- update_sreg is honoured independently of branch_op. CBZ/CBNZ with update_sreg load the flags.
- Illegal branch_op behaves as no branch (PC += 4), sets bad_op and leaves the counter unchanged.
- With advance low: no state changes, taken goes low, and every other output holds.

## Timing
- Reset values, asserted asynchronously and held while rst_n is low: pc=RESET_PC, flags=0000, taken=0, branch_count=0, bad_op=0.
- Retire-to-update latency is one edge. The new PC, flags and taken are visible the cycle after advance.
- A reset mid-stream discards any in-flight decision. The first edge after release with advance high updates from RESET_PC.
- branch_count saturates at 2^CNT_WIDTH−1 and never wraps.
- bad_op clears only on reset.
- All outputs come straight from registers, with no combinational input-to-output path.

## Structure
- Shared include constants.vh holds:
  - the branch_op encodings (BR_NONE, BR_B, BR_COND, BR_CBZ, BR_CBNZ);
  - the 16 condition-code constants;
  - the NZCV bit indices.
- One combinational sub-module, cond_eval: inputs flags[3:0] and cond[3:0], output true. It is instantiated once.
- The top level contains the PC register, flags register, counter, sticky bit and adders.

## Test plan
- Reset then advance with branch_op=000 for 3 cycles -> pc 0x0, 0x4, 0x8, 0xC; taken stays 0.
- pc=0x100, branch_op=001, offset=−4 (all-ones−3) -> pc=0xF0, taken=1 for one cycle, branch_count=1.
- update_sreg with alu_z=1, then next cycle B.cond EQ (0000), offset=2 -> taken.
  - Same cycle update_sreg with alu_z=1 plus B.cond EQ on old flags 0000 -> not taken, flags become 0100.
- CBZ with alu_z=0 -> pc+4. CBNZ with alu_z=0 and offset=8 -> pc+32. With advance low for any op -> pc unchanged.
- pc=2^64−4, branch_op=000 -> pc=0. Counter preset at all-ones, taken B -> count stays all-ones.
- branch_op=110 retired -> pc+4, bad_op=1 and stays 1 through later ops. rst_n pulsed mid-cycle -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/branch_unit_pkg.sv
// Shared encodings for the branch unit: branch_op values, ARM condition codes, NZCV bit positions.
// Helpers classify branch_op. Nothing in this file is clocked.
package branch_unit_pkg;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_B    = 3'b001;
  localparam logic [2:0] BR_COND = 3'b010;
  localparam logic [2:0] BR_CBZ  = 3'b011;
  localparam logic [2:0] BR_CBNZ = 3'b100;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_HS = 4'h2;
  localparam logic [3:0] COND_LO = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  function automatic logic is_legal_op(input logic [2:0] op);
    return (op <= BR_CBNZ);
  endfunction

endpackage

// File: rtl/branch_unit_cond_eval.sv
// Combinational ARM condition-code evaluator: zero latency, no flow control.
// AL and NV both evaluate true.
module cond_eval
  import branch_unit_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [3:0] cond,
  output logic       true
);

  logic w_n;
  logic w_z;
  logic w_c;
  logic w_v;
  logic w_hi;
  logic w_ge;
  logic w_gt;

  assign w_n  = flags[FLAG_N];
  assign w_z  = flags[FLAG_Z];
  assign w_c  = flags[FLAG_C];
  assign w_v  = flags[FLAG_V];
  assign w_hi = w_c & ~w_z;
  assign w_ge = (w_n == w_v);
  assign w_gt = ~w_z & w_ge;

  always_comb begin
    true = 1'b0;
    case (cond)
      COND_EQ: true = w_z;
      COND_NE: true = ~w_z;
      COND_HS: true = w_c;
      COND_LO: true = ~w_c;
      COND_MI: true = w_n;
      COND_PL: true = ~w_n;
      COND_VS: true = w_v;
      COND_VC: true = ~w_v;
      COND_HI: true = w_hi;
      COND_LS: true = ~w_hi;
      COND_GE: true = w_ge;
      COND_LT: true = ~w_ge;
      COND_GT: true = w_gt;
      COND_LE: true = ~w_gt;
      COND_AL: true = 1'b1;
      COND_NV: true = 1'b1;
      default: true = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_unit.sv
// Next-PC and NZCV unit for the non-pipelined LEGv8 core; one edge from retire to new PC/flags/taken.
// No backpressure: state moves only on cycles where advance is high, otherwise everything holds.
module branch_unit
  import branch_unit_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  advance,
  input  logic [2:0]            branch_op,
  input  logic                  update_sreg,
  input  logic                  alu_n,
  input  logic                  alu_z,
  input  logic                  alu_c,
  input  logic                  alu_v,
  input  logic [3:0]            cond,
  input  logic [ADDR_WIDTH-1:0] offset,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [3:0]            flags,
  output logic                  taken,
  output logic [CNT_WIDTH-1:0]  branch_count,
  output logic                  bad_op
);

  logic [ADDR_WIDTH-1:0] r_pc;
  nzcv_t                 r_flags;
  logic                  r_taken;
  logic [CNT_WIDTH-1:0]  r_count;
  logic                  r_bad;

  logic [ADDR_WIDTH-1:0] w_target;
  logic [ADDR_WIDTH-1:0] w_fall;
  logic                  w_cond_true;
  logic                  w_taken;
  logic                  w_illegal;
  nzcv_t                 w_alu_flags;

  // Both adders wrap modulo 2^ADDR_WIDTH on purpose.
  assign w_target    = r_pc + (offset << 2);
  assign w_fall      = r_pc + ADDR_WIDTH'(4);
  assign w_illegal   = ~is_legal_op(branch_op);
  assign w_alu_flags = '{n: alu_n, z: alu_z, c: alu_c, v: alu_v};

  // B.cond looks at the registered flags, so a same-cycle update cannot steer it.
  cond_eval u_cond_eval (
    .flags (r_flags),
    .cond  (cond),
    .true  (w_cond_true)
  );

  always_comb begin
    w_taken = 1'b0;
    case (branch_op)
      BR_B:    w_taken = 1'b1;
      BR_COND: w_taken = w_cond_true;
      BR_CBZ:  w_taken = alu_z;
      BR_CBNZ: w_taken = ~alu_z;
      default: w_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= RESET_PC;
      r_flags <= '0;
      r_taken <= 1'b0;
      r_count <= '0;
      r_bad   <= 1'b0;
    end else if (advance) begin
      r_pc    <= w_taken ? w_target : w_fall;
      r_taken <= w_taken;
      if (update_sreg) begin
        r_flags <= w_alu_flags;
      end
      if (w_taken && !(&r_count)) begin
        r_count <= r_count + CNT_WIDTH'(1);
      end
      if (w_illegal) begin
        r_bad <= 1'b1;
      end
    end else begin
      r_taken <= 1'b0;
    end
  end

  assign pc           = r_pc;
  assign flags        = r_flags;
  assign taken        = r_taken;
  assign branch_count = r_count;
  assign bad_op       = r_bad;

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit: vector table for single-cycle behaviour, hand sequences for reset, wrap and saturation.
module tb_branch_unit;
  import branch_unit_pkg::*;

  localparam int AW = 64;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          advance;
  logic [2:0]    branch_op;
  logic          update_sreg;
  logic          alu_n;
  logic          alu_z;
  logic          alu_c;
  logic          alu_v;
  logic [3:0]    cond;
  logic [AW-1:0] offset;
  logic [AW-1:0] pc;
  logic [3:0]    flags;
  logic          taken;
  logic [CW-1:0] branch_count;
  logic          bad_op;

  int checks;
  int errors;

  branch_unit #(
    .ADDR_WIDTH (AW),
    .RESET_PC   ('0),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .advance      (advance),
    .branch_op    (branch_op),
    .update_sreg  (update_sreg),
    .alu_n        (alu_n),
    .alu_z        (alu_z),
    .alu_c        (alu_c),
    .alu_v        (alu_v),
    .cond         (cond),
    .offset       (offset),
    .pc           (pc),
    .flags        (flags),
    .taken        (taken),
    .branch_count (branch_count),
    .bad_op       (bad_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          adv;
    logic [2:0]    op;
    logic          upd;
    logic [3:0]    alu;
    logic [3:0]    cnd;
    logic [AW-1:0] off;
    logic [AW-1:0] e_pc;
    logic [3:0]    e_fl;
    logic          e_tk;
    logic [CW-1:0] e_cnt;
    logic          e_bad;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic adv, input logic [2:0] op, input logic upd,
                              input logic [3:0] alu, input logic [3:0] cnd, input logic [AW-1:0] off,
                              input logic [AW-1:0] e_pc, input logic [3:0] e_fl, input logic e_tk,
                              input logic [CW-1:0] e_cnt, input logic e_bad);
    vec_t v;
    v.adv = adv; v.op = op; v.upd = upd; v.alu = alu; v.cnd = cnd; v.off = off;
    v.e_pc = e_pc; v.e_fl = e_fl; v.e_tk = e_tk; v.e_cnt = e_cnt; v.e_bad = e_bad;
    return v;
  endfunction

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic adv, input logic [2:0] op, input logic upd,
                       input logic [3:0] alu, input logic [3:0] cnd, input logic [AW-1:0] off);
    advance = adv; branch_op = op; update_sreg = upd;
    {alu_n, alu_z, alu_c, alu_v} = alu;
    cond = cnd; offset = off;
  endtask

  task automatic check_all(input string tag, input logic [AW-1:0] e_pc, input logic [3:0] e_fl,
                           input logic e_tk, input logic [CW-1:0] e_cnt, input logic e_bad);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".flags"}, AW'(flags), AW'(e_fl));
    chk({tag, ".taken"}, AW'(taken), AW'(e_tk));
    chk({tag, ".count"}, AW'(branch_count), AW'(e_cnt));
    chk({tag, ".bad_op"}, AW'(bad_op), AW'(e_bad));
  endtask

  // Pulse reset across one edge; leaves time at posedge+1 with rst_n released.
  task automatic do_reset();
    drive(1'b0, BR_NONE, 1'b0, 4'h0, 4'h0, '0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive(1'b1, BR_B, 1'b1, 4'hF, 4'h0, 64'd9);

    vecs[0]  = mk(1, BR_NONE, 0, 4'b0000, COND_EQ, 64'd0,    64'h4,   4'h0, 0, 0,  0);
    vecs[1]  = mk(1, BR_NONE, 0, 4'b0000, COND_EQ, 64'd0,    64'h8,   4'h0, 0, 0,  0);
    vecs[2]  = mk(1, BR_NONE, 0, 4'b0000, COND_EQ, 64'd0,    64'hC,   4'h0, 0, 0,  0);
    vecs[3]  = mk(1, BR_B,    0, 4'b0000, COND_EQ, 64'd61,   64'h100, 4'h0, 1, 1,  0);
    vecs[4]  = mk(1, BR_B,    0, 4'b0000, COND_EQ, -64'sd4,  64'hF0,  4'h0, 1, 2,  0);
    vecs[5]  = mk(0, BR_NONE, 0, 4'b0000, COND_EQ, 64'd0,    64'hF0,  4'h0, 0, 2,  0);
    vecs[6]  = mk(1, BR_NONE, 1, 4'b0100, COND_EQ, 64'd0,    64'hF4,  4'h4, 0, 2,  0);
    vecs[7]  = mk(1, BR_COND, 0, 4'b0000, COND_EQ, 64'd2,    64'hFC,  4'h4, 1, 3,  0);
    vecs[8]  = mk(1, BR_COND, 0, 4'b0000, COND_NE, 64'd2,    64'h100, 4'h4, 0, 3,  0);
    vecs[9]  = mk(1, BR_NONE, 1, 4'b0000, COND_EQ, 64'd0,    64'h104, 4'h0, 0, 3,  0);
    vecs[10] = mk(1, BR_COND, 1, 4'b0100, COND_EQ, 64'd2,    64'h108, 4'h4, 0, 3,  0);
    vecs[11] = mk(1, BR_CBZ,  0, 4'b0000, COND_EQ, 64'd8,    64'h10C, 4'h4, 0, 3,  0);
    vecs[12] = mk(1, BR_CBNZ, 0, 4'b0000, COND_EQ, 64'd8,    64'h12C, 4'h4, 1, 4,  0);
    vecs[13] = mk(1, BR_CBZ,  1, 4'b0110, COND_EQ, -64'sd2,  64'h124, 4'h6, 1, 5,  0);
    vecs[14] = mk(1, BR_CBNZ, 0, 4'b0100, COND_EQ, 64'd8,    64'h128, 4'h6, 0, 5,  0);
    vecs[15] = mk(0, BR_B,    1, 4'b1111, COND_EQ, 64'd100,  64'h128, 4'h6, 0, 5,  0);
    vecs[16] = mk(1, 3'b110,  0, 4'b0000, COND_EQ, 64'd8,    64'h12C, 4'h6, 0, 5,  1);
    vecs[17] = mk(1, BR_COND, 0, 4'b0000, COND_HI, 64'd8,    64'h130, 4'h6, 0, 5,  1);
    vecs[18] = mk(1, BR_NONE, 1, 4'b1001, COND_EQ, 64'd0,    64'h134, 4'h9, 0, 5,  1);
    vecs[19] = mk(1, BR_COND, 0, 4'b0000, COND_GE, 64'd4,    64'h144, 4'h9, 1, 6,  1);
    vecs[20] = mk(1, BR_COND, 0, 4'b0000, COND_LT, 64'd4,    64'h148, 4'h9, 0, 6,  1);
    vecs[21] = mk(1, BR_COND, 0, 4'b0000, COND_GT, 64'd4,    64'h158, 4'h9, 1, 7,  1);
    vecs[22] = mk(1, BR_COND, 0, 4'b0000, COND_MI, -64'sd1,  64'h154, 4'h9, 1, 8,  1);
    vecs[23] = mk(1, BR_COND, 0, 4'b0000, COND_VC, 64'd1,    64'h158, 4'h9, 0, 8,  1);
    vecs[24] = mk(1, BR_COND, 0, 4'b0000, COND_NV, 64'd1,    64'h15C, 4'h9, 1, 9,  1);
    vecs[25] = mk(1, BR_COND, 0, 4'b0000, COND_LS, 64'd1,    64'h160, 4'h9, 1, 10, 1);
    vecs[26] = mk(1, 3'b101,  0, 4'b0000, COND_EQ, 64'd8,    64'h164, 4'h9, 0, 10, 1);
    vecs[27] = mk(1, 3'b111,  0, 4'b0000, COND_EQ, 64'd8,    64'h168, 4'h9, 0, 10, 1);

    // Edges pass while reset is held with advance high: state must stay at reset values.
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 64'h0, 4'h0, 1'b0, '0, 1'b0);

    drive(1'b0, BR_NONE, 1'b0, 4'h0, 4'h0, '0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].adv, vecs[i].op, vecs[i].upd, vecs[i].alu, vecs[i].cnd, vecs[i].off);
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_fl, vecs[i].e_tk,
                vecs[i].e_cnt, vecs[i].e_bad);
    end

    // Asynchronous reset mid-cycle discards state immediately and holds across edges.
    drive(1'b1, BR_B, 1'b1, 4'hF, COND_AL, 64'd5);
    #3;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 64'h0, 4'h0, 1'b0, '0, 1'b0);
    @(posedge clk);
    #1;
    check_all("rst_hold", 64'h0, 4'h0, 1'b0, '0, 1'b0);
    rst_n = 1'b1;
    drive(1'b1, BR_NONE, 1'b0, 4'h0, COND_EQ, '0);
    @(posedge clk);
    #1;
    check_all("post_rst", 64'h4, 4'h0, 1'b0, '0, 1'b0);

    // PC wrap-around on both the fall-through and the target adder.
    do_reset();
    drive(1'b1, BR_B, 1'b0, 4'h0, COND_EQ, -64'sd1);
    @(posedge clk);
    #1;
    check_all("wrap_neg", 64'hFFFF_FFFF_FFFF_FFFC, 4'h0, 1'b1, 4'd1, 1'b0);
    drive(1'b1, BR_NONE, 1'b0, 4'h0, COND_EQ, '0);
    @(posedge clk);
    #1;
    check_all("wrap_fall", 64'h0, 4'h0, 1'b0, 4'd1, 1'b0);
    drive(1'b1, BR_B, 1'b0, 4'h0, COND_EQ, -64'sd1);
    @(posedge clk);
    #1;
    drive(1'b1, BR_B, 1'b0, 4'h0, COND_EQ, 64'd2);
    @(posedge clk);
    #1;
    check_all("wrap_tgt", 64'h4, 4'h0, 1'b1, 4'd3, 1'b0);

    // Counter saturates at all-ones and never wraps.
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      drive(1'b1, BR_B, 1'b0, 4'h0, COND_EQ, 64'd1);
      @(posedge clk);
      #1;
      chk($sformatf("sat%0d.count", i), AW'(branch_count), AW'((i > 15) ? 15 : i));
      chk($sformatf("sat%0d.pc", i), pc, AW'(4 * i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
